// File: rtl/data_mem_subword_pkg.sv
// Shared definitions for the sub-word data memory.
//   SZ_*            : Size field encodings (byte/half/word/reserved)
//   state_t         : controller states
//   lane_enables()  : per-lane write enables for a store (bit 3 = lane 0)
//   store_replicate(): store data copied onto every lane it could land in
package data_mem_subword_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // Lane 0 sits in bits [31:24], so enable bit 3 belongs to lane 0 and a
  // right shift by the lane number walks toward the low byte.
  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] lane);
    logic [3:0] en;
    case (size)
      SZ_BYTE: en = 4'b1000 >> lane;
      SZ_HALF: en = lane[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Right-aligned store data is replicated so any enabled lane already
  // holds the correct byte; the enables then pick the lanes to update.
  function automatic logic [31:0] store_replicate(input logic [1:0]  size,
                                                  input logic [31:0] wdata);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{wdata[7:0]}};
      SZ_HALF: rep = {2{wdata[15:0]}};
      default: rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/data_mem_subword_if.sv
// Request/response bundle of the sub-word data memory.
//   master : drives Address, Write_Data, MemWrite, MemRead, Size, Unsigned
//   slave  : drives Ready, Read_data, Read_valid, Addr_err
interface data_mem_subword_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] Address;
  logic [31:0]       Write_Data;
  logic              MemWrite;
  logic              MemRead;
  logic [1:0]        Size;
  logic              Unsigned;
  logic              Ready;
  logic [31:0]       Read_data;
  logic              Read_valid;
  logic              Addr_err;

  modport master (
    output Address, Write_Data, MemWrite, MemRead, Size, Unsigned,
    input  Ready, Read_data, Read_valid, Addr_err
  );

  modport slave (
    input  Address, Write_Data, MemWrite, MemRead, Size, Unsigned,
    output Ready, Read_data, Read_valid, Addr_err
  );

endinterface

// File: rtl/data_mem_subword_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of a
// big-endian word and sign- or zero-extends it to 32 bits.
//   word         : full memory word
//   lane         : byte lane (Address[1:0])
//   size         : SZ_BYTE / SZ_HALF / SZ_WORD
//   unsigned_ext : 1 = zero-extend, 0 = sign-extend
//   result       : aligned, extended load value
module load_align
  import data_mem_subword_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsigned_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Lane 0 is the most significant byte.
    byte_sel = word[(3 - lane) * 8 +: 8];
    half_sel = lane[1] ? word[15:0] : word[31:16];
    result   = '0;
    case (size)
      SZ_BYTE: result = unsigned_ext ? {24'h0, byte_sel}
                                     : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: result = unsigned_ext ? {16'h0, half_sel}
                                     : {{16{half_sel[15]}}, half_sel};
      SZ_WORD: result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_subword.sv
// Word-organised data memory with byte/half/word loads and stores.
//   CLK   : clock, all state on the rising edge
//   RESET : asynchronous, active-low
//   bus   : request/response bundle (slave side)
// Loads have one cycle of latency and read the pre-store contents when a
// store to the same word is accepted in the same cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zero-filling one word per cycle, requests ignored, Ready=0
// ST_IDLE  | Ready=1, one request (load, store or both) accepted/cycle
module data_mem_subword
  import data_mem_subword_pkg::*;
#(
  parameter int DEPTH          = 512,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  data_mem_subword_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  state_t           state;
  logic [IDX_W-1:0] clr_ptr;

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic             size_bad;
  logic             misaligned;
  logic             range_bad;
  logic             req_err;
  logic             accept;
  logic             do_store;
  logic [3:0]       wr_en;
  logic [31:0]      wr_rep;
  logic [31:0]      rd_word;
  logic [31:0]      rd_aligned;

  assign word_idx   = bus.Address[IDX_W+1:2];
  assign lane       = bus.Address[1:0];
  assign size_bad   = (bus.Size == SZ_RSVD);
  assign misaligned = ((bus.Size == SZ_HALF) && bus.Address[0]) ||
                      ((bus.Size == SZ_WORD) && (bus.Address[1:0] != 2'b00));
  // Any address bit above the word index means the word is beyond DEPTH.
  assign range_bad  = |(bus.Address >> (IDX_W + 2));
  assign req_err    = size_bad || misaligned || range_bad;

  // Ready is registered, so it already encodes "in IDLE and out of reset".
  assign accept     = bus.Ready && (bus.MemRead || bus.MemWrite);
  assign do_store   = bus.Ready && bus.MemWrite && !req_err;
  assign wr_en      = lane_enables(bus.Size, lane);
  assign wr_rep     = store_replicate(bus.Size, bus.Write_Data);
  assign rd_word    = mem[word_idx];

  load_align u_load_align (
    .word         (rd_word),
    .lane         (lane),
    .size         (bus.Size),
    .unsigned_ext (bus.Unsigned),
    .result       (rd_aligned)
  );

  // Storage has no reset; zero-fill happens only through the CLEAR walk.
  always_ff @(posedge CLK) begin
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (do_store) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_en[3-l]) begin
          mem[word_idx][31-8*l -: 8] <= wr_rep[31-8*l -: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_ptr        <= '0;
      bus.Ready      <= 1'b0;
      bus.Read_data  <= '0;
      bus.Read_valid <= 1'b0;
      bus.Addr_err   <= 1'b0;
    end else begin
      bus.Read_valid <= 1'b0;
      bus.Addr_err   <= 1'b0;
      case (state)
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == IDX_W'(DEPTH - 1)) begin
            state     <= ST_IDLE;
            bus.Ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          bus.Ready <= 1'b1;
          if (accept) begin
            bus.Addr_err <= req_err;
            if (bus.MemRead) begin
              bus.Read_valid <= 1'b1;
              bus.Read_data  <= req_err ? 32'h0 : rd_aligned;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus.Ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_subword.sv
module tb_data_mem_subword;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 32;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  data_mem_subword_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_subword #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (1)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference memory kept as a flat big-endian byte array.
  logic [7:0]  mb [4*DEPTH];
  logic [31:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == B) ? 1 : (sz == H) ? 2 : 4;
  endfunction

  function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == R) || (sz == H && a[0]) || (sz == W && a[1:0] != 2'b00) ||
           (a >= 32'(4*DEPTH));
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a);
    int n = nbytes(sz);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(mb[int'(a) + i]);
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*(n-1-i) +: 8];
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
  endtask

  // One request, sampled at the next rising edge; outputs checked 1 ns later.
  task automatic op(input logic wr, input logic rd, input logic [1:0] sz,
                    input logic uns, input logic [31:0] a, input logic [31:0] wd,
                    input string tag);
    bit e;
    e = (wr || rd) && m_err(sz, a);
    if (rd) exp_rd = e ? 32'h0 : m_load(sz, uns, a);
    bus.MemWrite   = wr;
    bus.MemRead    = rd;
    bus.Size       = sz;
    bus.Unsigned   = uns;
    bus.Address    = a;
    bus.Write_Data = wd;
    @(posedge CLK);
    #1;
    if (wr && !e) m_store(sz, a, wd);
    check({tag, ".valid"}, 32'(bus.Read_valid), 32'(rd));
    check({tag, ".data"},  bus.Read_data, exp_rd);
    check({tag, ".err"},   32'(bus.Addr_err), 32'(e));
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    while (!bus.Ready && n < 2000) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    RESET          = 1'b0;
    bus.Address    = '0;
    bus.Write_Data = '0;
    bus.MemWrite   = 1'b0;
    bus.MemRead    = 1'b0;
    bus.Size       = W;
    bus.Unsigned   = 1'b0;
    exp_rd         = 32'h0;
    m_clear();

    #12;
    check("rst.ready", 32'(bus.Ready), 32'h0);
    check("rst.valid", 32'(bus.Read_valid), 32'h0);
    check("rst.err",   32'(bus.Addr_err), 32'h0);
    check("rst.data",  bus.Read_data, 32'h0);

    @(posedge CLK);
    #1;
    RESET = 1'b1;
    wait_ready("clear_len", DEPTH);

    for (int i = 0; i < 4; i++)
      op(0, 1, W, 0, 32'($urandom_range(0, DEPTH-1)) << 2, 0, "zero_ld");
    op(0, 1, W, 0, 32'(4*(DEPTH-1)), 0, "zero_ld_last");

    // Byte merge into an existing word.
    op(1, 0, W, 0, 32'h10, 32'h11223344, "st_w10");
    op(1, 0, B, 0, 32'h12, 32'h000000AA, "st_b12");
    op(0, 1, W, 0, 32'h10, 0, "ld_w10");
    check("merge_lit", bus.Read_data, 32'h1122AA44);

    // Sub-word extraction and extension.
    op(1, 0, W, 0, 32'h20, 32'h80FF7F01, "st_w20");
    op(0, 1, B, 0, 32'h20, 0, "lb20");
    check("lb_lit", bus.Read_data, 32'hFFFFFF80);
    op(0, 1, B, 1, 32'h21, 0, "lbu21");
    check("lbu_lit", bus.Read_data, 32'h000000FF);
    op(0, 1, H, 0, 32'h22, 0, "lh22");
    check("lh_lit", bus.Read_data, 32'h00007F01);
    op(0, 1, H, 1, 32'h20, 0, "lhu20");
    check("lhu_lit", bus.Read_data, 32'h000080FF);

    // Error cases leave memory alone and return zero on loads.
    op(0, 1, W, 0, 32'h22, 0, "err_ld_mis");
    op(1, 0, H, 0, 32'h21, 32'h0000BEEF, "err_st_mis");
    op(1, 1, R, 0, 32'h20, 32'h12345678, "err_rsvd");
    op(1, 1, W, 0, 32'(4*DEPTH), 32'hDEADBEEF, "err_range");
    op(0, 1, W, 0, 32'h20, 0, "post_err");
    check("post_err_lit", bus.Read_data, 32'h80FF7F01);
    op(0, 1, W, 0, 32'h0, 0, "post_err0");
    check("post_err0_lit", bus.Read_data, 32'h0);

    // Read-before-write, then read-after-write.
    op(1, 0, W, 0, 32'h30, 32'h9, "st30");
    op(1, 1, W, 0, 32'h30, 32'h5, "rbw30");
    check("rbw_lit", bus.Read_data, 32'h9);
    op(0, 1, W, 0, 32'h30, 0, "raw30");
    check("raw_lit", bus.Read_data, 32'h5);

    // Back-to-back random traffic.
    for (int i = 0; i < 400; i++) begin
      sz = ($urandom_range(0, 15) == 0) ? R : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0)
        a = 32'(4*DEPTH) + 32'($urandom_range(0, 4000));
      else
        a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0 && sz == H) a[0] = 1'b0;
      if ($urandom_range(0, 3) != 0 && sz == W) a[1:0] = 2'b00;
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
         1'($urandom_range(0, 1)), a, $urandom, "rnd");
    end

    // A load whose result is cut off by reset must not show up afterwards.
    bus.MemRead = 1'b1;
    bus.Size    = W;
    bus.Address = 32'h10;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    bus.MemRead = 1'b0;
    #1;
    check("discard.async_valid", 32'(bus.Read_valid), 32'h0);
    check("discard.async_ready", 32'(bus.Ready), 32'h0);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("discard.valid", 32'(bus.Read_valid), 32'h0);

    // Reset part way through the clear walk restarts it from word 0.
    for (int i = 1; i < 100; i++) begin
      @(posedge CLK);
      #1;
    end
    check("mid_clear.ready", 32'(bus.Ready), 32'h0);
    RESET = 1'b0;
    #2;
    RESET = 1'b1;
    wait_ready("clear_restart_len", DEPTH);
    m_clear();
    exp_rd = 32'h0;
    op(0, 1, W, 0, 32'h10, 0, "recleared10");
    op(0, 1, W, 0, 32'h20, 0, "recleared20");
    op(0, 1, B, 0, 32'h30, 0, "recleared30");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
